// File: rtl/card_display_arbiter.sv
// Round-robin arbiter that lets three requesters share one two-digit hex display,
// holding each granted value for HOLD_CYCLES cycles followed by a one-cycle blank gap.
module card_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [5:0] val0,
  input  logic [5:0] val1,
  input  logic [5:0] val2,
  output logic [2:0] grant,
  output logic [5:0] disp_val,
  output logic       disp_valid,
  output logic [2:0] done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [25:0] LOAD = 26'(HOLD_CYCLES - 1);

  state_t      state;
  logic [25:0] count;
  logic [1:0]  last_grant;

  logic [1:0]  pick_idx;
  logic        pick_any;
  logic [5:0]  pick_val;
  logic        held;

  // Round-robin search: start one past the last winner and take the first asserted bit.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pick_idx = 2'd0;
    pick_any = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (int'(last_grant) + 1 + k) % 3;
      if (!pick_any && req[idx]) begin
        pick_any = 1'b1;
        pick_idx = 2'(idx);
      end
    end
  end

  always_comb begin
    pick_val = val0;
    case (pick_idx)
      2'd1:    pick_val = val1;
      2'd2:    pick_val = val2;
      default: pick_val = val0;
    endcase
  end

  // The granted requester is still asking while its req bit stays high.
  assign held = |(req & grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 3'b000;
      disp_val   <= 6'd0;
      disp_valid <= 1'b0;
      done       <= 3'b000;
      busy       <= 1'b0;
      count      <= 26'd0;
      last_grant <= 2'd2;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      done <= 3'b000;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state      <= HOLD;
            grant      <= 3'b001 << pick_idx;
            disp_val   <= pick_val;
            disp_valid <= 1'b1;
            count      <= LOAD;
            last_grant <= pick_idx;
            busy       <= 1'b1;
          end
        end
        HOLD: begin
          if (!held) begin
            state      <= GAP;
            grant      <= 3'b000;
            disp_valid <= 1'b0;
          end else if (count == 26'd0) begin
            state      <= GAP;
            done       <= grant;
            grant      <= 3'b000;
            disp_valid <= 1'b0;
          end else begin
            count <= count - 26'd1;
          end
        end
        GAP: begin
          // disp_val is left alone so the last value survives the blank gap.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          grant      <= 3'b000;
          disp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_display_arbiter.sv
// Self-checking bench for card_display_arbiter with HOLD_CYCLES=4: directed cycle checks
// plus a scoreboard of expected grants and done pulses consumed by a monitor.
module tb_card_display_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [5:0] val0, val1, val2;
  logic [2:0] grant;
  logic [5:0] disp_val;
  logic       disp_valid;
  logic [2:0] done;
  logic       busy;

  int tests    = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] g;
    logic [5:0] v;
  } exp_t;

  exp_t       gq[$];
  logic [2:0] dq[$];

  card_display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .val0      (val0),
    .val1      (val1),
    .val2      (val2),
    .grant     (grant),
    .disp_val  (disp_val),
    .disp_valid(disp_valid),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: on every new grant and every done pulse, pop and compare the scoreboard.
  logic [2:0] prev_grant = 3'b000;
  always @(negedge clk) begin
    if (!reset) begin
      check("onehot_grant", 32'($onehot0(grant)), 32'd1);
      if (grant != 3'b000 && prev_grant == 3'b000) begin
        if (gq.size() == 0) begin
          check("sb_grant_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = gq.pop_front();
          check("sb_grant", 32'(grant), 32'(e.g));
          check("sb_disp_val", 32'(disp_val), 32'(e.v));
          check("sb_disp_valid", 32'(disp_valid), 32'd1);
        end
      end
      if (done != 3'b000) begin
        if (dq.size() == 0) begin
          check("sb_done_unexpected", 32'(done), 32'd0);
        end else begin
          logic [2:0] d;
          d = dq.pop_front();
          check("sb_done", 32'(done), 32'(d));
          check("done_in_gap_grant", 32'(grant), 32'd0);
        end
      end
    end
    prev_grant = grant;
  end

  initial begin
    reset = 1'b1;
    req   = 3'b000;
    val0  = 6'd0;
    val1  = 6'd0;
    val2  = 6'd0;
    tick(2);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_disp_val", 32'(disp_val), 32'd0);
    check("rst_valid", 32'(disp_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(2);
    check("idle_grant", 32'(grant), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Single request: four hold cycles, done on entry to GAP, then IDLE.
    gq.push_back('{g: 3'b001, v: 6'd37});
    dq.push_back(3'b001);
    req  = 3'b001;
    val0 = 6'd37;
    tick(1);
    check("single_grant", 32'(grant), 32'b001);
    check("single_val", 32'(disp_val), 32'd37);
    check("single_valid", 32'(disp_valid), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    tick(HOLD - 1);
    check("single_last_hold", 32'(disp_valid), 32'd1);
    tick(1);
    check("single_gap_done", 32'(done), 32'b001);
    check("single_gap_valid", 32'(disp_valid), 32'd0);
    check("single_gap_busy", 32'(busy), 32'd1);
    req = 3'b000;
    tick(1);
    check("single_idle_done", 32'(done), 32'd0);
    check("single_idle_busy", 32'(busy), 32'd0);

    // Simultaneous requests after reset rotate 0,1,2,0 with grants HOLD+2 apart.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    val0 = 6'd1;
    val1 = 6'd2;
    val2 = 6'd3;
    gq.push_back('{g: 3'b001, v: 6'd1});
    gq.push_back('{g: 3'b010, v: 6'd2});
    gq.push_back('{g: 3'b100, v: 6'd3});
    gq.push_back('{g: 3'b001, v: 6'd1});
    dq.push_back(3'b001);
    dq.push_back(3'b010);
    dq.push_back(3'b100);
    dq.push_back(3'b001);
    req = 3'b111;
    tick(1);
    check("rr_grant0", 32'(grant), 32'b001);
    tick(HOLD + 2);
    check("rr_grant1", 32'(grant), 32'b010);
    tick(HOLD + 2);
    check("rr_grant2", 32'(grant), 32'b100);
    tick(HOLD + 2);
    check("rr_grant3", 32'(grant), 32'b001);
    tick(HOLD);
    check("rr_final_done", 32'(done), 32'b001);
    req = 3'b000;
    tick(1);

    // Frozen value: val1 changes mid-hold but the display keeps the latched value.
    gq.push_back('{g: 3'b010, v: 6'd12});
    dq.push_back(3'b010);
    req  = 3'b010;
    val1 = 6'd12;
    tick(1);
    check("frz_grant", 32'(grant), 32'b010);
    val1 = 6'd50;
    tick(1);
    check("frz_val_mid", 32'(disp_val), 32'd12);
    tick(2);
    check("frz_val_end", 32'(disp_val), 32'd12);
    tick(1);
    check("frz_done", 32'(done), 32'b010);
    req = 3'b000;
    tick(1);

    // Abort: requester 0 withdraws during the second hold cycle; no done pulse.
    gq.push_back('{g: 3'b001, v: 6'd5});
    req  = 3'b001;
    val0 = 6'd5;
    tick(1);
    check("abort_grant", 32'(grant), 32'b001);
    tick(1);
    req = 3'b000;
    tick(1);
    check("abort_gap_grant", 32'(grant), 32'd0);
    check("abort_gap_valid", 32'(disp_valid), 32'd0);
    check("abort_gap_done", 32'(done), 32'd0);
    check("abort_gap_busy", 32'(busy), 32'd1);
    tick(1);
    check("abort_idle_busy", 32'(busy), 32'd0);

    // Reset mid-hold clears everything; then requester 1 wins first from req=110.
    gq.push_back('{g: 3'b001, v: 6'd9});
    req  = 3'b001;
    val0 = 6'd9;
    tick(2);
    reset = 1'b1;
    tick(1);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_val", 32'(disp_val), 32'd0);
    check("mid_rst_valid", 32'(disp_valid), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    gq.push_back('{g: 3'b010, v: 6'd20});
    dq.push_back(3'b010);
    req  = 3'b110;
    val1 = 6'd20;
    val2 = 6'd30;
    tick(1);
    check("post_rst_grant", 32'(grant), 32'b010);
    tick(HOLD);
    check("post_rst_done", 32'(done), 32'b010);
    req = 3'b000;
    tick(1);

    // Boundary values on requester 2, back to back: 63 then 0.
    gq.push_back('{g: 3'b100, v: 6'd63});
    gq.push_back('{g: 3'b100, v: 6'd0});
    dq.push_back(3'b100);
    dq.push_back(3'b100);
    req  = 3'b100;
    val2 = 6'd63;
    tick(1);
    check("bnd_val63", 32'(disp_val), 32'd63);
    check("bnd_valid63", 32'(disp_valid), 32'd1);
    tick(HOLD);
    check("bnd_done63", 32'(done), 32'b100);
    check("bnd_gap_keep", 32'(disp_val), 32'd63);
    val2 = 6'd0;
    tick(2);
    check("bnd_val0", 32'(disp_val), 32'd0);
    check("bnd_valid0", 32'(disp_valid), 32'd1);
    tick(HOLD);
    check("bnd_done0", 32'(done), 32'b100);
    req = 3'b000;
    tick(2);

    check("sb_grant_left", 32'(gq.size()), 32'd0);
    check("sb_done_left", 32'(dq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
